adda_stream: RTL and testbench
==============================

ADDA_STREAM -- requirements
Module: adda_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: ADC and DAC sample width in bits.
REQ-002 SHALL have parameter DIV, default 2, minimum 1: converter clock half-period in system clocks, so the sample period is 2*DIV clocks.
REQ-003 SHALL have parameter DEPTH, default 256, power of 2: capture buffer depth in samples.
REQ-004 SHALL have port clk_25mhz  input  1  system clock; the block SHALL use this one clock and it is the only clock.
REQ-005 SHALL have port i_reset  input  1  reset; synchronous to clk_25mhz and active-high.
REQ-006 SHALL have port i_mode  input  2  output mode: 00 pass, 01 mask, 10 ramp, 11 replay.
REQ-007 SHALL have port i_capture  input  1  capture request; level-sampled on each clock.
REQ-008 SHALL have port AD_PORT  input  WIDTH  ADC parallel data.
REQ-009 SHALL have port DA_PORT  output  WIDTH  DAC parallel data; registered.
REQ-010 SHALL have port ADCLK  output  1  ADC sample clock.
REQ-011 SHALL have port DACLK  output  1  DAC latch clock.
REQ-012 SHALL have port o_busy  output  1  capture in progress.
REQ-013 SHALL have port o_full  output  1  capture buffer holds a complete record.
REQ-014 SHALL have port wifi_gpio0  output  1  constant 1, which keeps the ESP32 out of reboot.

Function
REQ-015 SHALL count phase counter ph from 0 to 2*DIV-1 and then wrap to 0.
REQ-016 SHALL drive ADCLK=1 while ph<DIV and drive DACLK as the inverse of ADCLK.
REQ-017 SHALL define the tick as the single clock cycle where ph==2*DIV-1; AD_PORT SHALL be sampled only on the tick.
REQ-018 SHALL update DA_PORT only on the tick, so the new value is visible one clock after the tick edge and is stable across the following rising edge of DACLK.
REQ-019 SHALL drive DA_PORT to the current AD_PORT value in pass mode.
REQ-020 SHALL drive DA_PORT to (AD_PORT bitwise-AND ramp) in mask mode; the operation SHALL be bitwise, not logical.
REQ-021 SHALL drive DA_PORT to the ramp value in ramp mode.
REQ-022 SHALL increment the WIDTH-bit ramp counter on every tick in all modes and wrap it from 2^WIDTH-1 to 0.
REQ-023 SHALL sample i_mode on the tick, so that a mode change takes effect at the next tick.
REQ-024 SHALL accept i_capture high while o_busy=0 and start a capture: o_busy=1 and o_full=0 from the next clock, write address 0.
REQ-025 SHALL, while o_busy=1, write AD_PORT to the buffer at the write address on each tick and then increment the write address.
REQ-026 SHALL, on the tick that writes address DEPTH-1, clear o_busy and set o_full on the next clock.
REQ-027 SHALL ignore i_capture while o_busy=1.
REQ-028 SHALL, in replay mode, output buffer[rd] on each tick and advance rd, wrapping from DEPTH-1 to 0.
REQ-029 SHALL reset rd to 0 on the tick at which the mode changes to replay.
REQ-030 SHALL output 0 in replay mode while o_full=0, including while a capture is in progress.
REQ-031 SHALL continue the capture when a capture runs concurrently with any mode.

Reset
REQ-032 SHALL, while i_reset=1, hold ph=0, DA_PORT=0, ramp=0, o_busy=0, o_full=0, and the write and read pointers at 0.
REQ-033 SHALL therefore hold ADCLK=1 and DACLK=0 during reset.
REQ-034 SHALL abort any capture in progress when reset is asserted, leaving o_full=0; buffer contents are don't-care.
REQ-035 SHALL produce the first tick 2*DIV clocks after reset is deasserted.

Configuration
REQ-036 SHALL compile in the capture buffer, capture logic and replay mode when macro ADDA_CAPTURE_EN is defined.
REQ-037 SHALL, when ADDA_CAPTURE_EN is undefined, instantiate no buffer, ignore i_capture, tie o_busy=0 and o_full=0, and treat mode 11 as pass.

Verification (WIDTH=8, DIV=2, DEPTH=16)
REQ-038 SHALL cover reset: hold i_reset for 3 clocks, then release -> DA_PORT=0x00, o_busy=0, o_full=0, ADCLK=1, DACLK=0; first tick occurs 4 clocks after release.
REQ-039 SHALL cover pass mode: AD_PORT=0xA5 -> DA_PORT=0xA5 one clock after the next tick; ADCLK and DACLK have a period of 4 clocks and are in antiphase.
REQ-040 SHALL cover ramp mode from reset -> DA_PORT=0x00, 0x01, ... with one step per 4 clocks, wrapping 0xFF->0x00 after 256 ticks.
REQ-041 SHALL cover mask mode: AD_PORT=0xF0 while ramp=0x3C -> DA_PORT=0x30.
REQ-042 SHALL cover capture and replay: drive AD_PORT=tick index 0..15, pulse i_capture -> o_busy high for 16 ticks then o_full=1; then mode 11 -> DA_PORT=0x00..0x0F, repeating.
REQ-043 SHALL cover capture boundary cases: i_capture pulsed again while busy is ignored; i_reset asserted at sample 8 -> o_busy=0 and o_full=0, and replay outputs 0x00; with ADDA_CAPTURE_EN undefined, mode 11 behaves as pass.

Source files
------------

// File: rtl/adda_stream.sv
// adda_stream: paced ADC->DAC stream with pass, mask, ramp and replay modes.
// Define ADDA_CAPTURE_EN to build in the capture buffer and replay mode.
module adda_stream #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2,
  parameter int DEPTH = 256
) (
  input  logic             clk_25mhz,
  input  logic             i_reset,
  input  logic [1:0]       i_mode,
  input  logic             i_capture,
  input  logic [WIDTH-1:0] AD_PORT,
  output logic [WIDTH-1:0] DA_PORT,
  output logic             ADCLK,
  output logic             DACLK,
  output logic             o_busy,
  output logic             o_full,
  output logic             wifi_gpio0
);

  typedef enum logic [1:0] {
    M_PASS   = 2'b00,
    M_MASK   = 2'b01,
    M_RAMP   = 2'b10,
    M_REPLAY = 2'b11
  } mode_t;

  localparam int PW = (DIV > 1) ? $clog2(2 * DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(2 * DIV - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(DIV);

  logic [PW-1:0]    r_ph;
  logic             w_tick;
  logic [WIDTH-1:0] r_ramp;
  logic [WIDTH-1:0] r_da;
  logic [WIDTH-1:0] w_da;
  logic [WIDTH-1:0] w_replay;
  mode_t            w_mode;

  assign w_tick     = (r_ph == PH_LAST);
  assign w_mode     = mode_t'(i_mode);
  assign ADCLK      = (r_ph < PH_HALF);
  assign DACLK      = ~ADCLK;
  assign DA_PORT    = r_da;
  assign wifi_gpio0 = 1'b1;

  always_ff @(posedge clk_25mhz) begin
    if (i_reset) begin
      r_ph <= '0;
    end else if (w_tick) begin
      r_ph <= '0;
    end else begin
      r_ph <= r_ph + PW'(1);
    end
  end

`ifdef ADDA_CAPTURE_EN
  typedef enum logic [1:0] {
    CS_IDLE,
    CS_BUSY,
    CS_FULL
  } cap_t;

  localparam int AW = $clog2(DEPTH);

  cap_t             r_cs;
  cap_t             w_cs_nx;
  logic             w_wr;
  logic             w_start;
  logic [AW-1:0]    r_wa;
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    w_rd;
  mode_t            r_mode;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_comb begin
    w_cs_nx = r_cs;
    w_wr    = 1'b0;
    w_start = 1'b0;
    unique case (r_cs)
      CS_BUSY: begin
        if (w_tick) begin
          w_wr = 1'b1;
          if (r_wa == AW'(DEPTH - 1)) w_cs_nx = CS_FULL;
        end
      end
      default: begin
        if (i_capture) begin
          w_start = 1'b1;
          w_cs_nx = CS_BUSY;
        end
      end
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (i_reset) begin
      r_cs <= CS_IDLE;
      r_wa <= '0;
    end else begin
      r_cs <= w_cs_nx;
      if (w_start) r_wa <= '0;
      else if (w_wr) r_wa <= r_wa + AW'(1);
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (w_wr) r_mem[r_wa] <= AD_PORT;
  end

  // Entering replay restarts playback from the first captured sample.
  assign w_rd     = (r_mode != M_REPLAY) ? '0 : r_rd;
  assign w_replay = (r_cs == CS_FULL) ? r_mem[w_rd] : '0;

  always_ff @(posedge clk_25mhz) begin
    if (i_reset) begin
      r_mode <= M_PASS;
      r_rd   <= '0;
    end else if (w_tick) begin
      r_mode <= w_mode;
      if (w_mode == M_REPLAY) r_rd <= w_rd + AW'(1);
    end
  end

  assign o_busy = (r_cs == CS_BUSY);
  assign o_full = (r_cs == CS_FULL);
`else
  logic w_unused_cap;

  assign w_unused_cap = i_capture;
  assign w_replay     = AD_PORT;
  assign o_busy       = 1'b0;
  assign o_full       = 1'b0;
`endif

  always_comb begin
    w_da = r_da;
    unique case (w_mode)
      M_PASS:   w_da = AD_PORT;
      M_MASK:   w_da = AD_PORT & r_ramp;
      M_RAMP:   w_da = r_ramp;
      M_REPLAY: w_da = w_replay;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (i_reset) begin
      r_da   <= '0;
      r_ramp <= '0;
    end else if (w_tick) begin
      r_da   <= w_da;
      r_ramp <= r_ramp + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_adda_stream.sv
// tb_adda_stream: random and directed stimulus for adda_stream
// against a behavioural model of the sample-rate stream.
module tb_adda_stream;
  localparam int W     = 8;
  localparam int DIV   = 2;
  localparam int DEPTH = 16;
  localparam int PER   = 2 * DIV;

  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic [1:0]   i_mode = 2'b00;
  logic         i_capture = 1'b0;
  logic [W-1:0] ad = '0;
  logic [W-1:0] da;
  logic         adclk;
  logic         daclk;
  logic         busy;
  logic         full;
  logic         gpio0;

  adda_stream #(.WIDTH(W), .DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk_25mhz (clk),
    .i_reset   (i_reset),
    .i_mode    (i_mode),
    .i_capture (i_capture),
    .AD_PORT   (ad),
    .DA_PORT   (da),
    .ADCLK     (adclk),
    .DACLK     (daclk),
    .o_busy    (busy),
    .o_full    (full),
    .wifi_gpio0(gpio0)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: clocks since reset, ticks since reset, capture record.
  int         m_cnt = 0;
  int         m_ticks = 0;
  logic [7:0] m_da = '0;
  bit         m_busy = 0;
  bit         m_full = 0;
  bit         m_valid = 0;
`ifdef ADDA_CAPTURE_EN
  int         m_rd = 0;
  int         m_wn = 0;
  int         m_prev = 0;
  logic [7:0] m_buf [DEPTH];
`endif

  initial forever begin : model
    bit         tick;
    logic [7:0] ramp;
`ifdef ADDA_CAPTURE_EN
    bit         ob;
    bit         of;
`endif
    @(posedge clk);
    if (i_reset) begin
      m_cnt   = 0;
      m_ticks = 0;
      m_da    = '0;
      m_busy  = 0;
      m_full  = 0;
      m_valid = 1;
`ifdef ADDA_CAPTURE_EN
      m_rd    = 0;
      m_prev  = 0;
`endif
    end else begin
      tick = ((m_cnt % PER) == PER - 1);
      m_cnt++;
`ifdef ADDA_CAPTURE_EN
      ob = m_busy;
      of = m_full;
`endif
      if (tick) begin
        ramp = 8'(m_ticks % 256);
        case (i_mode)
          2'd0: m_da = ad;
          2'd1: m_da = ad & ramp;
          2'd2: m_da = ramp;
          default: begin
`ifdef ADDA_CAPTURE_EN
            if (m_prev != 3) m_rd = 0;
            m_da = of ? m_buf[m_rd] : 8'h00;
            m_rd = (m_rd + 1) % DEPTH;
`else
            m_da = ad;
`endif
          end
        endcase
`ifdef ADDA_CAPTURE_EN
        m_prev = int'(i_mode);
`endif
        m_ticks++;
      end
`ifdef ADDA_CAPTURE_EN
      if (!ob && i_capture) begin
        m_busy = 1;
        m_full = 0;
        m_wn   = 0;
      end else if (ob && tick) begin
        m_buf[m_wn] = ad;
        m_wn++;
        if (m_wn == DEPTH) begin
          m_busy = 0;
          m_full = 1;
        end
      end
`endif
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (m_valid) begin
      chk("DA_PORT", da, m_da);
      chk("ADCLK", adclk, ((m_cnt % PER) < DIV) ? 1 : 0);
      chk("DACLK", daclk, ((m_cnt % PER) < DIV) ? 0 : 1);
      chk("o_busy", busy, m_busy);
      chk("o_full", full, m_full);
      chk("wifi_gpio0", gpio0, 1);
    end
  end

  task automatic step();
    @(negedge clk);
    rc++;
  endtask

  task automatic adv_tick();
    int g = 0;
    do begin
      step();
      g++;
    end while ((rc % PER) != 0 && g < 2 * PER);
  endtask

  task automatic do_reset(int n);
    i_reset = 1'b1;
    repeat (n) @(negedge clk);
    i_reset = 1'b0;
    rc = 0;
  endtask

  initial begin : main
    ad = 8'hA5;
    do_reset(3);
    chk("rst_DA", da, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ADCLK", adclk, 1);
    chk("rst_DACLK", daclk, 0);
    repeat (3) step();
    chk("pre_tick_DA", da, 8'h00);
    step();
    chk("first_tick_DA", da, 8'hA5);
    ad = 8'h3C;
    adv_tick();
    chk("pass_DA", da, 8'h3C);
    for (int i = 0; i < PER; i++) begin
      chk("clk_ADCLK", adclk, (i < DIV) ? 1 : 0);
      chk("clk_DACLK", daclk, (i < DIV) ? 0 : 1);
      step();
    end

    i_mode = 2'b10;
    do_reset(2);
    for (int t = 1; t <= 257; t++) begin
      adv_tick();
      if (t == 1)   chk("ramp_t1", da, 8'h00);
      if (t == 2)   chk("ramp_t2", da, 8'h01);
      if (t == 256) chk("ramp_t256", da, 8'hFF);
      if (t == 257) chk("ramp_wrap", da, 8'h00);
    end

    i_mode = 2'b01;
    ad = 8'hF0;
    do_reset(2);
    repeat (61) adv_tick();
    chk("mask_F0_3C", da, 8'h30);

`ifdef ADDA_CAPTURE_EN
    i_mode = 2'b00;
    ad = 8'h00;
    do_reset(2);
    i_capture = 1'b1;
    step();
    i_capture = 1'b0;
    chk("cap_busy", busy, 1);
    chk("cap_full0", full, 0);
    while (rc < 70) begin
      ad = 8'(rc / PER);
      i_capture = (rc == 20);
      if (rc == 62) chk("cap_busy_late", busy, 1);
      step();
    end
    i_capture = 1'b0;
    chk("cap_done_busy", busy, 0);
    chk("cap_done_full", full, 1);
    i_mode = 2'b11;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      ad = 8'($urandom);
      adv_tick();
      chk("replay", da, i % DEPTH);
    end

    i_mode = 2'b00;
    do_reset(2);
    i_capture = 1'b1;
    step();
    i_capture = 1'b0;
    repeat (8) adv_tick();
    chk("abort_busy_pre", busy, 1);
    do_reset(1);
    chk("abort_busy", busy, 0);
    chk("abort_full", full, 0);
    i_mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ad = 8'($urandom);
      adv_tick();
      chk("abort_replay", da, 8'h00);
    end
    chk("abort_full_late", full, 0);
`else
    i_mode = 2'b11;
    ad = 8'h5A;
    do_reset(2);
    adv_tick();
    chk("m11_pass", da, 8'h5A);
    i_capture = 1'b1;
    step();
    i_capture = 1'b0;
    chk("nocap_busy", busy, 0);
    chk("nocap_full", full, 0);
`endif

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) i_mode = 2'($urandom);
      ad = 8'($urandom);
      i_capture = ($urandom_range(0, 59) == 0);
      i_reset = ($urandom_range(0, 1499) == 0);
      step();
    end
    i_reset = 1'b0;
    i_capture = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
